// File: rtl/ram_march_bist.sv
// March BIST engine for a bit-wide RAM: M0 ascending w0, M1 ascending r0/w1,
// M2 descending r1/w0. Reports pass, or the first failing address and element.
module ram_march_bist #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [1:0]            fail_element,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_write_enable,
  output logic                  mem_write_data,
  output logic                  mem_read_enable,
  input  logic                  mem_read_data
);

  localparam logic [ADDR_WIDTH-1:0] ADDR_LAST  = {ADDR_WIDTH{1'b1}};
  localparam logic [ADDR_WIDTH-1:0] ADDR_FIRST = '0;
  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);

  typedef enum logic [2:0] {
    IDLE,
    M0_W,
    M1_R,
    M1_W,
    M2_R,
    M2_W,
    DONE
  } state_t;

  state_t state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      fail_addr        <= '0;
      fail_element     <= 2'd0;
      mem_addr         <= '0;
      mem_write_enable <= 1'b0;
      mem_write_data   <= 1'b0;
      mem_read_enable  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            state            <= M0_W;
            busy             <= 1'b1;
            pass             <= 1'b0;
            fail_addr        <= '0;
            fail_element     <= 2'd0;
            mem_addr         <= '0;
            mem_write_enable <= 1'b1;
            mem_write_data   <= 1'b0;
            mem_read_enable  <= 1'b0;
          end
        end

        M0_W: begin
          if (mem_addr == ADDR_LAST) begin
            state            <= M1_R;
            mem_addr         <= ADDR_FIRST;
            mem_write_enable <= 1'b0;
            mem_read_enable  <= 1'b1;
          end else begin
            mem_addr <= mem_addr + ADDR_ONE;
          end
        end

        M1_R: begin
          state            <= M1_W;
          mem_read_enable  <= 1'b0;
          mem_write_enable <= 1'b1;
          mem_write_data   <= 1'b1;
        end

        // Read data from M1_R is valid here; the w1 strobe completes at this edge
        // regardless of the compare outcome.
        M1_W: begin
          mem_write_enable <= 1'b0;
          if (mem_read_data != 1'b0) begin
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            pass         <= 1'b0;
            fail_addr    <= mem_addr;
            fail_element <= 2'd1;
          end else if (mem_addr == ADDR_LAST) begin
            state           <= M2_R;
            mem_read_enable <= 1'b1;
          end else begin
            state           <= M1_R;
            mem_addr        <= mem_addr + ADDR_ONE;
            mem_read_enable <= 1'b1;
          end
        end

        M2_R: begin
          state            <= M2_W;
          mem_read_enable  <= 1'b0;
          mem_write_enable <= 1'b1;
          mem_write_data   <= 1'b0;
        end

        M2_W: begin
          mem_write_enable <= 1'b0;
          if (mem_read_data != 1'b1) begin
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            pass         <= 1'b0;
            fail_addr    <= mem_addr;
            fail_element <= 2'd2;
          end else if (mem_addr == ADDR_FIRST) begin
            state        <= DONE;
            busy         <= 1'b0;
            done         <= 1'b1;
            pass         <= 1'b1;
            fail_addr    <= '0;
            fail_element <= 2'd0;
          end else begin
            state           <= M2_R;
            mem_addr        <= mem_addr - ADDR_ONE;
            mem_read_enable <= 1'b1;
          end
        end

        // Start is deliberately not sampled here; IDLE must be re-entered first.
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
        end

        default: begin
          state            <= IDLE;
          busy             <= 1'b0;
          done             <= 1'b0;
          mem_write_enable <= 1'b0;
          mem_read_enable  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_march_bist.sv
// Bench for ram_march_bist: bit-wide RAM model with an optional stuck-at cell,
// abstract march reference model, protocol monitor and directed/random runs.
`timescale 1ns/1ps
module tb_ram_march_bist;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          busy, done, pass;
  logic [AW-1:0] fail_addr;
  logic [1:0]    fail_element;
  logic [AW-1:0] mem_addr;
  logic          mem_write_enable, mem_write_data, mem_read_enable;
  logic          mem_read_data = 1'b0;

  int checks     = 0;
  int failures   = 0;
  int edge_n     = 0;
  int done_count = 0;

  logic          ram [DEPTH];
  bit            fault_en   = 1'b0;
  int            fault_addr = 0;
  bit            fault_val  = 1'b0;
  bit            fill_req   = 1'b0;
  logic          prev_re    = 1'b0;
  logic [AW-1:0] prev_addr  = '0;

  always #5 clock = ~clock;

  ram_march_bist #(.ADDR_WIDTH(AW)) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .busy             (busy),
    .done             (done),
    .pass             (pass),
    .fail_addr        (fail_addr),
    .fail_element     (fail_element),
    .mem_addr         (mem_addr),
    .mem_write_enable (mem_write_enable),
    .mem_write_data   (mem_write_data),
    .mem_read_enable  (mem_read_enable),
    .mem_read_data    (mem_read_data)
  );

  always @(posedge clock) edge_n <= edge_n + 1;

  // RAM array: synchronous read, one optional stuck-at cell overriding reads.
  always @(posedge clock) begin
    if (fill_req) begin
      for (int i = 0; i < DEPTH; i++) ram[i] <= 1'($urandom_range(0, 1));
    end else if (mem_write_enable) begin
      ram[mem_addr] <= mem_write_data;
    end
    if (mem_read_enable)
      mem_read_data <= (fault_en && fault_addr == int'(mem_addr)) ? fault_val : ram[mem_addr];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (reset) begin
      prev_re <= 1'b0;
    end else begin
      check("we_re_exclusive", 32'(mem_write_enable & mem_read_enable), 32'd0);
      if (!busy) check("strobes_idle", 32'({mem_write_enable, mem_read_enable}), 32'd0);
      if (prev_re)
        check("read_then_write", 32'({mem_write_enable, mem_read_enable, mem_addr == prev_addr}), 32'b101);
      prev_re   <= mem_read_enable;
      prev_addr <= mem_addr;
      if (done) done_count <= done_count + 1;
    end
  end

  // March evaluated directly on an array: returns result and the done edge.
  function automatic void model(input bit en, input int fa, input bit fv,
                                output int t, output bit p, output int addr, output int elem);
    bit arr [DEPTH];
    bit rd;
    for (int a = 0; a < DEPTH; a++) arr[a] = 1'b0;
    t = 5 * DEPTH; p = 1'b1; addr = 0; elem = 0;
    for (int a = 0; a < DEPTH; a++) begin
      rd = (en && a == fa) ? fv : arr[a];
      if (rd != 1'b0) begin
        t = DEPTH + 2 * a + 2; p = 1'b0; addr = a; elem = 1;
        return;
      end
      arr[a] = 1'b1;
    end
    for (int a = DEPTH - 1; a >= 0; a--) begin
      rd = (en && a == fa) ? fv : arr[a];
      if (rd != 1'b1) begin
        t = 3 * DEPTH + 2 * (DEPTH - 1 - a) + 2; p = 1'b0; addr = a; elem = 2;
        return;
      end
      arr[a] = 1'b0;
    end
  endfunction

  function automatic logic [15:0] all_outputs();
    return {busy, done, pass, fail_addr, fail_element, mem_addr,
            mem_write_enable, mem_write_data, mem_read_enable};
  endfunction

  task automatic wait_done(input int st, input bit restarts, output bit got);
    got = 1'b0;
    for (int i = 0; i < 6 * DEPTH; i++) begin
      if (done) begin
        got = 1'b1;
        break;
      end
      if (restarts) start = (edge_n == st + 3 || edge_n == st + 40);
      @(negedge clock);
    end
    start = 1'b0;
  endtask

  task automatic check_result(input string tag, input int st, input bit got,
                              input int exp_t, input bit exp_p, input int exp_addr, input int exp_elem);
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    if (got) begin
      check({tag, "_done_edge"}, 32'(edge_n - 1 - st), 32'(exp_t));
      check({tag, "_result"}, 32'({busy, pass, fail_addr, fail_element}),
            32'({1'b0, exp_p, AW'(exp_addr), 2'(exp_elem)}));
    end
  endtask

  task automatic run(input string tag, input bit en, input int fa, input bit fv, input bit restarts);
    int st, exp_t, exp_addr, exp_elem, dc0;
    bit exp_p, got;
    logic [DEPTH-1:0] image;
    model(en, fa, fv, exp_t, exp_p, exp_addr, exp_elem);
    fault_en = en; fault_addr = fa; fault_val = fv;
    @(negedge clock); fill_req = 1'b1;
    @(negedge clock); fill_req = 1'b0;
    dc0   = done_count;
    start = 1'b1;
    st    = edge_n;
    @(negedge clock);
    start = 1'b0;
    check({tag, "_edge0"}, 32'(all_outputs()),
          32'({1'b1, 1'b0, 1'b0, {AW{1'b0}}, 2'b00, {AW{1'b0}}, 1'b1, 1'b0, 1'b0}));
    wait_done(st, restarts, got);
    check_result(tag, st, got, exp_t, exp_p, exp_addr, exp_elem);
    @(negedge clock);
    check({tag, "_done_pulse"}, 32'(done), 32'd0);
    check({tag, "_done_count"}, 32'(done_count - dc0), 32'd1);
    if (exp_p) begin
      for (int i = 0; i < DEPTH; i++) image[i] = ram[i];
      check({tag, "_array_zero"}, 32'(image), 32'd0);
    end
  endtask

  initial begin
    int st, dc0;
    bit got, en, fv;
    int fa;

    @(negedge clock);
    check("reset_state", 32'(all_outputs()), 32'd0);
    reset = 1'b0;
    @(negedge clock);

    run("clean", 1'b0, 0, 1'b0, 1'b0);
    run("sa1_cell5", 1'b1, 5, 1'b1, 1'b0);
    run("sa0_cell9", 1'b1, 9, 1'b0, 1'b0);
    run("restart_ignored", 1'b0, 0, 1'b0, 1'b1);

    // Reset mid-run: outputs clear asynchronously, no done pulse follows.
    fault_en = 1'b0;
    start = 1'b1;
    st = edge_n;
    @(negedge clock);
    start = 1'b0;
    for (int i = 0; i < 40 && edge_n != st + 30; i++) @(negedge clock);
    dc0 = done_count;
    reset = 1'b1;
    #1;
    check("async_reset_outputs", 32'(all_outputs()), 32'd0);
    repeat (3) @(negedge clock);
    check("reset_no_done", 32'({done, busy}), 32'd0);
    reset = 1'b0;
    @(negedge clock);
    check("reset_done_count", 32'(done_count - dc0), 32'd0);
    run("after_reset", 1'b0, 0, 1'b0, 1'b0);

    // Start held high: ignored in DONE, relaunches once IDLE is re-entered.
    start = 1'b1;
    st = edge_n;
    wait_done_held: begin
      got = 1'b0;
      for (int i = 0; i < 6 * DEPTH; i++) begin
        if (done) begin
          got = 1'b1;
          break;
        end
        @(negedge clock);
      end
    end
    check_result("held_start", st, got, 5 * DEPTH, 1'b1, 0, 0);
    @(negedge clock);
    check("held_start_done_state", 32'(busy), 32'd0);
    @(negedge clock);
    check("held_start_relaunch", 32'({busy, mem_write_enable, mem_addr}), 32'({1'b1, 1'b1, {AW{1'b0}}}));
    start = 1'b0;
    st = edge_n - 1;
    wait_done(st, 1'b0, got);
    check_result("held_start_second", st, got, 5 * DEPTH, 1'b1, 0, 0);
    @(negedge clock);

    for (int n = 0; n < 8; n++) begin
      en = ($urandom_range(0, 3) != 0);
      fa = $urandom_range(0, DEPTH - 1);
      fv = 1'($urandom_range(0, 1));
      run($sformatf("rand%0d", n), en, fa, fv, 1'b0);
    end

    repeat (3) @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
